// File: rtl/vertex_fetch.sv
// Vertex fetch engine: reads a header word (vertex count) and then x/y/z word
// triplets over an Avalon-MM read master, presenting each vertex on a valid/ready port.
module vertex_fetch #(
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] vertex_buffer_base,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       vtx_x,
  output logic [31:0]       vtx_y,
  output logic [31:0]       vtx_z,
  output logic              vtx_valid,
  input  logic              vtx_ready,
  output logic              vtx_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_REQ,
    HDR_WAIT,
    W_REQ,
    W_WAIT,
    OUT,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  vtx_total;
  logic [CNT_W-1:0]  vtx_cnt;
  logic [1:0]        word_idx;
  logic              is_last;

  assign is_last = (vtx_cnt == vtx_total - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = HDR_REQ;
      HDR_REQ:  if (!avm_waitrequest) state_nxt = HDR_WAIT;
      HDR_WAIT: if (avm_readdatavalid)
                  state_nxt = (avm_readdata[CNT_W-1:0] == '0) ? DONE : W_REQ;
      W_REQ:    if (!avm_waitrequest) state_nxt = W_WAIT;
      W_WAIT:   if (avm_readdatavalid)
                  state_nxt = (word_idx == 2'd2) ? OUT : W_REQ;
      OUT:      if (vtx_ready) state_nxt = is_last ? DONE : W_REQ;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // The address register always points at the next word to request, so it
  // advances on every accepted read and wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      vtx_total <= '0;
      vtx_cnt   <= '0;
      word_idx  <= '0;
      vtx_x     <= '0;
      vtx_y     <= '0;
      vtx_z     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= vertex_buffer_base;
            vtx_total <= '0;
            vtx_cnt   <= '0;
            word_idx  <= '0;
          end
        end
        HDR_REQ, W_REQ: begin
          if (!avm_waitrequest) addr <= addr + ADDR_W'(4);
        end
        HDR_WAIT: begin
          if (avm_readdatavalid) begin
            vtx_total <= avm_readdata[CNT_W-1:0];
            word_idx  <= '0;
          end
        end
        W_WAIT: begin
          if (avm_readdatavalid) begin
            case (word_idx)
              2'd0:    vtx_x <= avm_readdata;
              2'd1:    vtx_y <= avm_readdata;
              default: vtx_z <= avm_readdata;
            endcase
            word_idx <= (word_idx == 2'd2) ? 2'd0 : word_idx + 2'd1;
          end
        end
        OUT: begin
          if (vtx_ready) vtx_cnt <= vtx_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign avm_read    = (state == HDR_REQ) || (state == W_REQ);
  assign avm_address = addr;
  assign vtx_valid   = (state == OUT);
  assign vtx_last    = vtx_valid && is_last;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_vertex_fetch.sv
// Self-checking bench for vertex_fetch: the bench plays the Avalon slave and the
// vertex consumer, and checks every read and vertex against a buffer built from the layout rules.
module tb_vertex_fetch;

  localparam int ADDR_W = 22;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] vertex_buffer_base;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [31:0]       vtx_x, vtx_y, vtx_z;
  logic              vtx_valid;
  logic              vtx_ready;
  logic              vtx_last;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  vertex_fetch #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .vertex_buffer_base(vertex_buffer_base),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .vtx_x             (vtx_x),
    .vtx_y             (vtx_y),
    .vtx_z             (vtx_z),
    .vtx_valid         (vtx_valid),
    .vtx_ready         (vtx_ready),
    .vtx_last          (vtx_last),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full fetch of an n-vertex buffer: word k of the buffer lives at base+4k
  // (mod 2^ADDR_W), word 0 is the header, words 1..3n are x,y,z per vertex.
  task automatic run_fetch(input logic [ADDR_W-1:0] base, input int n, input bit seq,
                           input int wr_pct, input int rdy_pct, input int max_lat,
                           input int hold_read, input int hold_cycles, input int stall,
                           input bit noise);
    logic [31:0]       hdr;
    logic [31:0]       words [$];
    logic [ADDR_W-1:0] prev_addr, exp_addr;
    int r, pend_idx, lat, vi, hold_left, stall_left;
    bit pend, outstanding, prev_read, prev_wr, expect_done, finished;
    words = {};
    for (int k = 0; k < 3 * n; k++) words.push_back(seq ? 32'(k + 1) : $urandom);
    hdr = seq ? 32'(n) : (($urandom & 32'hFFFF_0000) | 32'(n));
    r = 0; pend_idx = 0; lat = 0; vi = 0;
    pend = 0; prev_read = 0; prev_wr = 0; expect_done = 0; finished = 0;
    prev_addr = '0;
    hold_left = hold_cycles;
    stall_left = stall;
    vertex_buffer_base = base;
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    vtx_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      total++;
      if (done !== expect_done) begin
        bad++;
        $display("[TB] FAIL done_timing: got %b expected %b (vertex %0d, reads %0d)", done, expect_done, vi, r);
      end
      if (done === 1'b1) begin
        total++;
        if (vi != n || r != 3 * n + 1) begin
          bad++;
          $display("[TB] FAIL completion_counts: vertices %0d reads %0d expected vertices %0d reads %0d", vi, r, n, 3 * n + 1);
        end
        start = noise;
        avm_readdatavalid = 1'b0;
        vtx_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || vtx_valid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL after_done: busy=%b done=%b valid=%b expected 0 0 0", busy, done, vtx_valid);
        end
        finished = 1;
      end else begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL busy: got %b expected 1", busy);
        end
        expect_done = 0;
        start = noise ? 1'($urandom_range(1)) : 1'b0;
        outstanding = pend;
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
        if (pend) begin
          if (lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = (pend_idx == 0) ? hdr : words[pend_idx - 1];
            pend = 0;
            if (pend_idx == 0 && n == 0) expect_done = 1;
          end else lat--;
        end else if (noise && $urandom_range(3) == 0) avm_readdatavalid = 1'b1;
        total++;
        if ((outstanding || vtx_valid === 1'b1) && avm_read !== 1'b0) begin
          bad++;
          $display("[TB] FAIL read_quiet: avm_read=%b expected 0 (outstanding=%0d valid=%b)", avm_read, outstanding, vtx_valid);
        end
        if (prev_read && prev_wr) begin
          total++;
          if (avm_read !== 1'b1 || avm_address !== prev_addr) begin
            bad++;
            $display("[TB] FAIL read_hold: read=%b addr=%h expected read=1 addr=%h", avm_read, avm_address, prev_addr);
          end
        end
        if (avm_read === 1'b1 && !outstanding) begin
          if (hold_read == r && hold_left > 0) begin
            avm_waitrequest = 1'b1;
            hold_left--;
          end else avm_waitrequest = ($urandom_range(99) < wr_pct);
          if (!avm_waitrequest) begin
            exp_addr = base + ADDR_W'(4 * r);
            total++;
            if (avm_address !== exp_addr || r > 3 * n) begin
              bad++;
              $display("[TB] FAIL read_addr: read %0d got %h expected %h (max reads %0d)", r, avm_address, exp_addr, 3 * n + 1);
            end
            pend = 1;
            pend_idx = r;
            lat = $urandom_range(max_lat);
            r++;
          end
        end else avm_waitrequest = 1'($urandom_range(1));
        prev_read = (avm_read === 1'b1);
        prev_wr = avm_waitrequest;
        prev_addr = avm_address;
        if (vtx_valid === 1'b1) begin
          total++;
          if (vi >= n) begin
            bad++;
            $display("[TB] FAIL vertex_extra: valid with vertex %0d expected only %0d vertices", vi, n);
          end else if (vtx_x !== words[3 * vi] || vtx_y !== words[3 * vi + 1] ||
                       vtx_z !== words[3 * vi + 2] || vtx_last !== (vi == n - 1)) begin
            bad++;
            $display("[TB] FAIL vertex: #%0d got (%h,%h,%h) last=%b expected (%h,%h,%h) last=%b", vi,
                     vtx_x, vtx_y, vtx_z, vtx_last, words[3 * vi], words[3 * vi + 1], words[3 * vi + 2], vi == n - 1);
          end
          if (stall_left > 0) begin
            vtx_ready = 1'b0;
            stall_left--;
          end else vtx_ready = ($urandom_range(99) < rdy_pct);
          if (vtx_ready) begin
            if (vi == n - 1) expect_done = 1;
            vi++;
          end
        end else vtx_ready = 1'($urandom_range(1));
        @(posedge clk); #1;
      end
    end
    if (!finished) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout: no done after 3000 cycles (vertices %0d reads %0d)", vi, r);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h0000_0005;
    avm_waitrequest = 1'b0;
    vtx_ready = 1'b1;
    vertex_buffer_base = 22'h12340;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || avm_read !== 1'b0 || avm_address !== '0 || vtx_valid !== 1'b0 ||
        vtx_last !== 1'b0 || done !== 1'b0 || vtx_x !== '0 || vtx_y !== '0 || vtx_z !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: busy=%b read=%b addr=%h valid=%b last=%b done=%b xyz=%h/%h/%h expected all 0",
               busy, avm_read, avm_address, vtx_valid, vtx_last, done, vtx_x, vtx_y, vtx_z);
    end
    reset = 1'b0;
    start = 1'b0;
    avm_readdatavalid = 1'b0;
    vtx_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    run_fetch(22'h300000, 2, 1'b1, 0, 100, 0, -1, 0, 0, 1'b0);
  endtask

  task automatic test_empty();
    run_fetch(22'h001000, 0, 1'b1, 0, 100, 2, -1, 0, 0, 1'b0);
  endtask

  task automatic test_waitrequest();
    run_fetch(22'h020000, 2, 1'b0, 0, 100, 1, 2, 5, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_fetch(22'h030100, 2, 1'b0, 0, 100, 0, -1, 0, 10, 1'b0);
  endtask

  task automatic test_wrap();
    run_fetch(22'h3FFFFC, 1, 1'b1, 0, 100, 0, -1, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] base;
    for (int i = 0; i < 12; i++) begin
      base = ADDR_W'($urandom) & ~ADDR_W'(3);
      if (i % 4 == 0) base = 22'h3FFFF0;
      run_fetch(base, $urandom_range(5), 1'b0, 30, 60, 3, -1, 0, 0, 1'b1);
    end
  endtask

  task automatic test_reset_midfetch();
    int  acc;
    bit  pend;
    acc = 0;
    pend = 0;
    vertex_buffer_base = 22'h000100;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    vtx_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && acc < 2; c++) begin
      avm_readdatavalid = pend;
      avm_readdata = (acc == 1) ? 32'd2 : 32'h0000_AAAA;
      pend = 0;
      if (avm_read === 1'b1) begin
        acc++;
        pend = 1;
      end
      @(posedge clk); #1;
    end
    avm_readdatavalid = 1'b0;
    total++;
    if (acc != 2 || avm_read !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midfetch_setup: reads=%0d read=%b busy=%b expected 2 0 1", acc, avm_read, busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hDEAD_BEEF;
    total++;
    if (busy !== 1'b0 || avm_read !== 1'b0 || avm_address !== '0 || vtx_valid !== 1'b0 ||
        vtx_last !== 1'b0 || done !== 1'b0 || vtx_x !== '0 || vtx_y !== '0 || vtx_z !== '0) begin
      bad++;
      $display("[TB] FAIL midfetch_reset: busy=%b read=%b addr=%h valid=%b done=%b xyz=%h/%h/%h expected all 0",
               busy, avm_read, avm_address, vtx_valid, done, vtx_x, vtx_y, vtx_z);
    end
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    total++;
    if (busy !== 1'b0 || vtx_x !== '0 || avm_address !== '0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stray_data: busy=%b x=%h addr=%h done=%b expected 0 0 0 0", busy, vtx_x, avm_address, done);
    end
    run_fetch(22'h002000, 1, 1'b0, 20, 80, 1, -1, 0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    vertex_buffer_base = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    vtx_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_empty();
    test_waitrequest();
    test_backpressure();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
